// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU result stage.
//   - FLAG_* : bit positions of N/Z/C/V inside the 4-bit flag vector.
//   - alu_flags_t : the packed {N,Z,C,V} flag vector.
//   - alu_entry_t : the {sum, flags} result entry for the 32-bit datapath.
//     Wider or narrower stages build the same shape with their own width.
//   - alu_derive_flags() : NZCV derivation from the adder outputs.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FLAG_W = 4;

    localparam int ALU_DEF_N = 32;

    typedef logic [FLAG_W-1:0] alu_flags_t;

    typedef struct packed {
        logic [ALU_DEF_N-1:0] sum;
        alu_flags_t           flags;
    } alu_entry_t;

    // The adder does not export its carry-out. It is recovered from the
    // operand MSBs and the sum MSB: both MSBs set always carry; exactly one
    // set carries only if the incoming carry into bit N-1 cleared the sum MSB.
    function automatic alu_flags_t alu_derive_flags(
        input logic sum_msb,
        input logic sum_zero,
        input logic a_msb,
        input logic b_msb,
        input logic ovf
    );
        alu_flags_t f;
        f         = '0;
        f[FLAG_N] = sum_msb;
        f[FLAG_Z] = sum_zero;
        f[FLAG_C] = (a_msb & b_msb) | ((a_msb ^ b_msb) & ~sum_msb);
        f[FLAG_V] = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// ---------------------------------------------------------------------------
// alu_skid_buf
//   Generic 2-entry valid/ready skid buffer. The main register drives the
//   output; the skid register catches one item when the main register is
//   full and not draining. in_ready is registered (it is !skid_valid).
//
//   Handshake: a transfer happens on a rising edge where valid && ready are
//   both high on that interface; valid, once raised, says the payload is
//   meaningful, and ready says the receiver takes it at that edge.
//
//   Ports
//     clk, rst            : clock, synchronous active-high reset
//     in_valid/in_ready   : upstream handshake
//     in_data  [W]        : upstream payload
//     out_valid/out_ready : downstream handshake
//     out_data [W]        : downstream payload (holds when empty)
// ---------------------------------------------------------------------------
module alu_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic [W-1:0] main_data_q,  main_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;

    logic accept;
    logic main_load;

    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    // Main register may take a new item when it is empty or emptying now.
    assign main_load = ~main_valid_q | (main_valid_q & out_ready);

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (main_load) begin
            // A held skid item is older than anything arriving, so it goes
            // first. While the skid is full, in_ready is low and accept is 0.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Registered result stage behind the carry-lookahead adder. Derives NZCV
//   flags at capture, stores them with the sum in a 2-entry skid buffer and
//   keeps a saturating count of accepted overflowed results.
//
//   Optional feature macro: ALU_STICKY_OVF_EN adds clr_sticky/sticky_ovf.
//
//   Ports
//     clk, rst             : clock, synchronous active-high reset
//     in_valid/in_ready    : upstream handshake (in_ready registered)
//     in_sum [N], in_ovf   : adder sum and signed overflow
//     in_a_msb, in_b_msb   : operand MSBs that produced in_sum
//     out_valid/out_ready  : downstream handshake
//     out_sum [N]          : registered sum
//     out_flags [4]        : {N,Z,C,V}
//     ovf_count [CNT_W]    : accepted V=1 results, saturating
//     clr_sticky           : clear sticky_ovf (ALU_STICKY_OVF_EN)
//     sticky_ovf           : sticky overflow (ALU_STICKY_OVF_EN)
// ---------------------------------------------------------------------------
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_sum,
    input  logic             in_ovf,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] ovf_count
`ifdef ALU_STICKY_OVF_EN
    ,
    input  logic             clr_sticky,
    output logic             sticky_ovf
`endif
);

    typedef struct packed {
        logic [N-1:0] sum;
        alu_flags_t   flags;
    } entry_t;

    entry_t     in_entry;
    entry_t     out_entry;
    logic       accept;
    logic       accept_ovf;

    assign in_entry.sum   = in_sum;
    assign in_entry.flags = alu_derive_flags(in_sum[N-1], (in_sum == '0),
                                             in_a_msb, in_b_msb, in_ovf);

    alu_skid_buf #(
        .W ($bits(entry_t))
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign out_sum   = out_entry.sum;
    assign out_flags = out_entry.flags;

    assign accept     = in_valid & in_ready;
    assign accept_ovf = accept & in_ovf;

    // Overflow counter: saturates at all-ones instead of wrapping.
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    always_comb begin
        ovf_count_d = ovf_count_q;
        if (accept_ovf && (ovf_count_q != {CNT_W{1'b1}})) begin
            ovf_count_d = ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;

`ifdef ALU_STICKY_OVF_EN
    // Set has priority over clear so an overflow in the clearing cycle
    // is not lost.
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (accept_ovf) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule
